serial_bit_tx: RTL and testbench
================================

Name: serial_bit_tx

Overview:
Parallel-to-serial transmitter that drives a single-bit D line into flop-based capture logic downstream.
- Accepts a word over a valid/ready handshake.
- Emits a framed bit stream on that line: start bit, data bits LSB first, optional parity, stop bit(s).
- Each bit is held for a fixed number of clock cycles.
- Serves as the driving end for any rising-edge sampled serial receiver in the design.

Parameters:
- DATA_W, 8, data bits per frame; legal range ≥1.
- CLKS_PER_BIT, 4, clock cycles each bit is held on the line; legal range ≥1.
- STOP_BITS, 1, number of stop bits (line high); legal range 1 or 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_W  word to send; sampled only on acceptance.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word this cycle.
- d_out  output  1  registered serial line; idle level 1.
- busy  output  1  frame in progress; equals ~tx_ready.
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst=1 at a clk edge) applies on the next edge:
  - d_out=1, tx_ready=1, busy=0, frame_done=0.
  - State IDLE; bit and cycle counters cleared.
- Reset mid-frame abandons the frame immediately. No stop bit is appended; the line returns to 1 on that edge.
- Acceptance: in any cycle T where tx_valid && tx_ready, tx_data is latched into the shift register.
  - tx_ready is 1 only in IDLE.
  - Changes on tx_data after T have no effect.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - START: d_out=0 for CLKS_PER_BIT cycles, covering T+1 .. T+CLKS_PER_BIT.
  - DATA: DATA_W bits LSB first, each held CLKS_PER_BIT cycles; shift right once per bit period.
  - STOP: d_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: FRAME = (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles, where P=1 if parity is compiled in, else 0.
  - d_out carries the frame in cycles T+1 .. T+FRAME.
  - IDLE is re-entered at T+FRAME+1, with tx_ready=1 and frame_done=1 for exactly that one cycle.
- Back-to-back: a word offered while busy waits; tx_valid may stay high.
  - Next acceptance is no earlier than T+FRAME+1.
  - Minimum spacing between frames is one idle-high cycle.
- Counters:
  - Cycle counter width = max(1, $clog2(CLKS_PER_BIT)); counts 0..CLKS_PER_BIT-1, then wraps.
  - Bit counter width = $clog2(DATA_W+1).
- CLKS_PER_BIT=1: every bit lasts one cycle; no special casing allowed.
- d_out is driven directly from a flop, never from combinational logic.
- tx_valid=1 during reset: ignored; acceptance is possible only from the first non-reset cycle.

Optional Feature:
- Macro SERIAL_BIT_TX_PARITY_EN.
- Defined: PARITY state inserted after the MSB.
  - d_out = XOR of the latched data bits (even parity), held CLKS_PER_BIT cycles.
  - P=1 in the FRAME formula.
- Undefined: PARITY state and parity logic absent; DATA transitions directly to STOP; P=0.

Decomposition:
- Shared package serial_bit_pkg:
  - State enum typedef (IDLE, START, DATA, PARITY, STOP).
  - LINE_IDLE=1'b1, START_LVL=1'b0.
  - Frame-length helper function, used by both RTL and bench.
- Sub-module bit_period_counter:
  - Parameter CLKS_PER_BIT; inputs clk, rst, en; output tick.
  - tick is high on the last cycle of each bit period.
  - FSM advances only on tick.

Test Plan:
- Reset then idle, no tx_valid for 20 cycles → d_out=1, tx_ready=1, busy=0, frame_done=0 throughout.
- Defaults, parity off; send 0xA5 at T → d_out pattern:
  - T+1..T+4 = 0 (start).
  - Data bits 1,0,1,0,0,1,0,1, 4 cycles each, T+5..T+36.
  - T+37..T+40 = 1 (stop).
  - frame_done=1 and tx_ready=1 at T+41 only.
- tx_valid held high with 0x00 then 0xFF → two frames; second start bit begins at T+42; d_out=1 at T+41.
- Assert rst at T+15 mid-frame → d_out=1 and tx_ready=1 from T+16; no frame_done; a new 0x3C frame then transmits correctly.
- CLKS_PER_BIT=1, STOP_BITS=2, send 0x01 → 0,1,0,0,0,0,0,0,0,1,1 over T+1..T+11; frame_done at T+12.
- SERIAL_BIT_TX_PARITY_EN defined:
  - Send 0x07 → parity bit 1 at T+37..T+40, stop at T+41..T+44, frame_done at T+45.
  - Send 0x03 → parity bit 0.

Source files
------------

// File: rtl/serial_bit_pkg.sv
// Shared definitions for the serial bit transmitter: state encoding,
// line levels and the frame-length helper.
// Optional feature macro: SERIAL_BIT_TX_PARITY_EN (even parity bit after MSB).
package serial_bit_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Number of clock cycles the line carries one complete frame.
  function automatic int frame_len(input int data_w, input int stop_bits,
                                   input int clks_per_bit, input int parity_bits);
    return (1 + data_w + parity_bits + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/serial_bit_tx_bit_period_counter.sv
// Bit-period timer: counts clock cycles within one bit while enabled and
// flags the last cycle of each period so the transmitter can advance.
module bit_period_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Cycle counter: held at zero while idle, wraps after the last cycle of a bit.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // With CLKS_PER_BIT=1 LAST is zero, so tick is high on every enabled cycle.
  assign tick = en && (count == LAST);

endmodule

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: accepts a word over valid/ready and sends
// start bit, data LSB first, optional parity, and stop bit(s), each bit held
// CLKS_PER_BIT cycles. d_out comes straight from a flop.
// Optional feature macro: SERIAL_BIT_TX_PARITY_EN (even parity bit after MSB).
module serial_bit_tx
  import serial_bit_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              d_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_next;
  logic [BW-1:0]     bit_cnt;
  logic              counting;
  logic              tick;
`ifdef SERIAL_BIT_TX_PARITY_EN
  logic              parity;
`endif

  assign shift_next = shift >> 1;
  assign counting   = (state != IDLE);

  bit_period_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_period (
    .clk (clk),
    .rst (rst),
    .en  (counting),
    .tick(tick)
  );

  // Frame sequencer: next line level is decided one cycle ahead so d_out stays a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      d_out      <= LINE_IDLE;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
`ifdef SERIAL_BIT_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift    <= tx_data;
`ifdef SERIAL_BIT_TX_PARITY_EN
            parity   <= ^tx_data;
`endif
            d_out    <= START_LVL;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            d_out <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef SERIAL_BIT_TX_PARITY_EN
              d_out   <= parity;
              state   <= PARITY;
`else
              d_out   <= LINE_IDLE;
              state   <= STOP;
`endif
            end else begin
              shift   <= shift_next;
              d_out   <= shift_next[0];
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        PARITY: begin
`ifdef SERIAL_BIT_TX_PARITY_EN
          if (tick) begin
            d_out <= LINE_IDLE;
            state <= STOP;
          end
`else
          // Unreachable without parity; fall back to idle.
          d_out    <= LINE_IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          bit_cnt  <= '0;
          state    <= IDLE;
`endif
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt    <= '0;
              tx_ready   <= 1'b1;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        default: begin
          d_out    <= LINE_IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          bit_cnt  <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Self-checking bench for serial_bit_tx: one instance with default parameters
// and one with CLKS_PER_BIT=1, STOP_BITS=2. Expected line values come from a
// frame model built as a list of bits from the word.
module tb_serial_bit_tx;
  import serial_bit_pkg::*;

  localparam int DW   = 8;
  localparam int CPB0 = 4;
  localparam int SB0  = 1;
  localparam int CPB1 = 1;
  localparam int SB1  = 2;
`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tx_data0 = '0;
  logic [DW-1:0] tx_data1 = '0;
  logic          tx_valid0 = 1'b0;
  logic          tx_valid1 = 1'b0;
  logic          tx_ready0, d_out0, busy0, frame_done0;
  logic          tx_ready1, d_out1, busy1, frame_done1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_bit_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB0), .STOP_BITS(SB0)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .d_out(d_out0), .busy(busy0), .frame_done(frame_done0)
  );

  serial_bit_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB1), .STOP_BITS(SB1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .d_out(d_out1), .busy(busy1), .frame_done(frame_done1)
  );

  task automatic sample(input int which, output logic d, output logic r,
                        output logic b, output logic f);
    if (which == 0) begin
      d = d_out0; r = tx_ready0; b = busy0; f = frame_done0;
    end else begin
      d = d_out1; r = tx_ready1; b = busy1; f = frame_done1;
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [DW-1:0] data);
    if (which == 0) begin
      tx_valid0 = v; tx_data0 = data;
    end else begin
      tx_valid1 = v; tx_data1 = data;
    end
  endtask

  // Called at the negedge of cycle T: offers data, then checks T+1 .. T+FRAME+1.
  // With hold set, tx_valid stays high so the caller can offer the next word at T+FRAME+1.
  task automatic expect_frame(input int which, input logic [DW-1:0] data,
                              input bit hold, input string tag);
    logic bits[$];
    int   cpb, sb, frame, ones;
    logic d, r, b, f, ed, er, ef;
    cpb = (which == 0) ? CPB0 : CPB1;
    sb  = (which == 0) ? SB0 : SB1;
    bits.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < DW; i++) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (P == 1) bits.push_back((ones % 2) == 1);
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    frame = bits.size() * cpb;
    tests++;
    if (frame != frame_len(DW, sb, cpb, P)) begin
      fails++;
      $display("FAIL %s frame_len: got %0d expected %0d", tag, frame_len(DW, sb, cpb, P), frame);
    end
    sample(which, d, r, b, f);
    tests++;
    if (r !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_at_offer: tx_ready=%b expected 1", tag, r);
    end
    drive(which, 1'b1, data);
    for (int k = 1; k <= frame + 1; k++) begin
      @(negedge clk);
      sample(which, d, r, b, f);
      drive(which, hold, DW'($urandom));
      if (k <= frame) begin
        ed = bits[(k - 1) / cpb]; er = 1'b0; ef = 1'b0;
      end else begin
        ed = 1'b1; er = 1'b1; ef = 1'b1;
      end
      tests++;
      if (d !== ed || r !== er || b !== ~er || f !== ef) begin
        fails++;
        $display("FAIL %s cycle T+%0d data=%h: d_out,tx_ready,busy,frame_done=%b%b%b%b expected %b%b%b%b",
                 tag, k, data, d, r, b, f, ed, er, ~er, ef);
      end
    end
  endtask

  task automatic test_reset();
    logic d, r, b, f;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b1, 8'hFF);
    drive(1, 1'b1, 8'hFF);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      for (int w = 0; w < 2; w++) begin
        sample(w, d, r, b, f);
        tests++;
        if (d !== 1'b1 || r !== 1'b1 || b !== 1'b0 || f !== 1'b0) begin
          fails++;
          $display("FAIL reset_idle dut%0d cycle %0d: d_out,tx_ready,busy,frame_done=%b%b%b%b expected 1100",
                   w, i, d, r, b, f);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_a5();
    expect_frame(0, 8'hA5, 1'b0, "a5");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    expect_frame(0, 8'h00, 1'b1, "b2b_first");
    expect_frame(0, 8'hFF, 1'b0, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] data;
    logic d, r, b, f, ed;
    data = 8'hC6;
    drive(0, 1'b1, data);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      sample(0, d, r, b, f);
      drive(0, 1'b0, DW'($urandom));
      ed = (k <= CPB0) ? 1'b0 : data[(k - 1 - CPB0) / CPB0];
      tests++;
      if (d !== ed || r !== 1'b0 || f !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_pre cycle T+%0d: d_out,tx_ready,frame_done=%b%b%b expected %b00",
                 k, d, r, f, ed);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample(0, d, r, b, f);
      tests++;
      if (d !== 1'b1 || r !== 1'b1 || b !== 1'b0 || f !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_idle cycle T+%0d: d_out,tx_ready,busy,frame_done=%b%b%b%b expected 1100",
                 16 + i, d, r, b, f);
      end
      @(negedge clk);
    end
    expect_frame(0, 8'h3C, 1'b0, "after_reset");
    @(negedge clk);
  endtask

  task automatic test_fast_two_stop();
    expect_frame(1, 8'h01, 1'b0, "cpb1_stop2");
    @(negedge clk);
  endtask

  task automatic test_parity();
`ifdef SERIAL_BIT_TX_PARITY_EN
    expect_frame(0, 8'h07, 1'b0, "parity_07");
    @(negedge clk);
    expect_frame(0, 8'h03, 1'b0, "parity_03");
    @(negedge clk);
`endif
  endtask

  task automatic test_random();
    int w, nw, gap;
    bit hold;
    w = $urandom_range(0, 1);
    for (int n = 0; n < 16; n++) begin
      nw   = $urandom_range(0, 1);
      hold = (nw == w) && ($urandom_range(0, 1) == 1) && (n < 15);
      expect_frame(w, DW'($urandom), hold, "random");
      if (!hold) begin
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
      end
      w = nw;
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_mid_reset();
    test_fast_two_stop();
    test_parity();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
